// File: rtl/regalu_sequencer.sv
// Sequences the register-read / ALU-latch / write-back phases of the register-array ALU
// datapath from a stream of RV32I R-type instructions.
module regalu_sequencer #(
    parameter int PHASE_LEN = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    input  logic [31:0]      instr,
    output logic             instr_ready,
    output logic [4:0]       R_Addr_A,
    output logic [4:0]       R_Addr_B,
    output logic [4:0]       W_Addr,
    output logic [3:0]       ALU_OP,
    output logic             Reg_Write,
    output logic             clk_RR,
    output logic             clk_F,
    output logic             clk_WB,
    output logic             busy,
    output logic             illegal,
    output logic [CNT_W-1:0] retired_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RR   = 2'd1,
        ST_EX   = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    localparam logic [3:0] PH_LAST = 4'(PHASE_LEN - 1);

    // Only OP-format words with an ALU-defined funct7/funct3 pairing are executed.
    function automatic logic is_legal_rtype(input logic [31:0] word);
        logic [6:0] opcode;
        logic [6:0] funct7;
        logic [2:0] funct3;
        logic       ok;
        opcode = word[6:0];
        funct7 = word[31:25];
        funct3 = word[14:12];
        if (opcode != 7'b0110011) begin
            ok = 1'b0;
        end else if (funct7 == 7'b0000000) begin
            ok = 1'b1;
        end else if (funct7 == 7'b0100000) begin
            ok = (funct3 == 3'b000) || (funct3 == 3'b101);
        end else begin
            ok = 1'b0;
        end
        return ok;
    endfunction

    state_t           state_q,     state_d;
    logic [3:0]       phase_q,     phase_d;
    logic             ready_q,     ready_d;
    logic [4:0]       addr_a_q,    addr_a_d;
    logic [4:0]       addr_b_q,    addr_b_d;
    logic [4:0]       addr_w_q,    addr_w_d;
    logic [3:0]       alu_op_q,    alu_op_d;
    logic             reg_write_q, reg_write_d;
    logic             clk_rr_q,    clk_rr_d;
    logic             clk_f_q,     clk_f_d;
    logic             clk_wb_q,    clk_wb_d;
    logic             busy_q,      busy_d;
    logic             illegal_q,   illegal_d;
    logic [CNT_W-1:0] retired_q,   retired_d;
    logic             phase_last_s;

    // Next-state and next-output computation; every output is the registered image of the state it enters.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        ready_d      = ready_q;
        addr_a_d     = addr_a_q;
        addr_b_d     = addr_b_q;
        addr_w_d     = addr_w_q;
        alu_op_d     = alu_op_q;
        reg_write_d  = reg_write_q;
        clk_rr_d     = clk_rr_q;
        clk_f_d      = clk_f_q;
        clk_wb_d     = clk_wb_q;
        busy_d       = busy_q;
        illegal_d    = 1'b0;
        retired_d    = retired_q;
        phase_last_s = (phase_q == PH_LAST);

        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    if (is_legal_rtype(instr)) begin
                        state_d  = ST_RR;
                        phase_d  = 4'd0;
                        ready_d  = 1'b0;
                        busy_d   = 1'b1;
                        clk_rr_d = 1'b1;
                        addr_a_d = instr[19:15];
                        addr_b_d = instr[24:20];
                        addr_w_d = instr[11:7];
                        alu_op_d = {instr[30], instr[14:12]};
                    end else begin
                        illegal_d = 1'b1;
                    end
                end else begin
                    illegal_d = 1'b0;
                end
            end
            ST_RR: begin
                if (phase_last_s) begin
                    state_d  = ST_EX;
                    phase_d  = 4'd0;
                    clk_rr_d = 1'b0;
                    clk_f_d  = 1'b1;
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            ST_EX: begin
                if (phase_last_s) begin
                    state_d     = ST_WB;
                    phase_d     = 4'd0;
                    clk_f_d     = 1'b0;
                    clk_wb_d    = 1'b1;
                    reg_write_d = (addr_w_q != 5'd0);
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            ST_WB: begin
                if (phase_last_s) begin
                    state_d     = ST_IDLE;
                    phase_d     = 4'd0;
                    clk_wb_d    = 1'b0;
                    reg_write_d = 1'b0;
                    ready_d     = 1'b1;
                    busy_d      = 1'b0;
                    retired_d   = retired_q + CNT_W'(1);
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                phase_d     = 4'd0;
                ready_d     = 1'b1;
                busy_d      = 1'b0;
                clk_rr_d    = 1'b0;
                clk_f_d     = 1'b0;
                clk_wb_d    = 1'b0;
                reg_write_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any in-flight instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            phase_q     <= 4'd0;
            ready_q     <= 1'b1;
            addr_a_q    <= 5'd0;
            addr_b_q    <= 5'd0;
            addr_w_q    <= 5'd0;
            alu_op_q    <= 4'd0;
            reg_write_q <= 1'b0;
            clk_rr_q    <= 1'b0;
            clk_f_q     <= 1'b0;
            clk_wb_q    <= 1'b0;
            busy_q      <= 1'b0;
            illegal_q   <= 1'b0;
            retired_q   <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            ready_q     <= ready_d;
            addr_a_q    <= addr_a_d;
            addr_b_q    <= addr_b_d;
            addr_w_q    <= addr_w_d;
            alu_op_q    <= alu_op_d;
            reg_write_q <= reg_write_d;
            clk_rr_q    <= clk_rr_d;
            clk_f_q     <= clk_f_d;
            clk_wb_q    <= clk_wb_d;
            busy_q      <= busy_d;
            illegal_q   <= illegal_d;
            retired_q   <= retired_d;
        end
    end

    assign instr_ready = ready_q;
    assign R_Addr_A    = addr_a_q;
    assign R_Addr_B    = addr_b_q;
    assign W_Addr      = addr_w_q;
    assign ALU_OP      = alu_op_q;
    assign Reg_Write   = reg_write_q;
    assign clk_RR      = clk_rr_q;
    assign clk_F       = clk_f_q;
    assign clk_WB      = clk_wb_q;
    assign busy        = busy_q;
    assign illegal     = illegal_q;
    assign retired_cnt = retired_q;

endmodule

// File: tb/tb_regalu_sequencer.sv
// Bench for regalu_sequencer: two instances (PHASE_LEN 1 and 3) share one stimulus stream and are
// compared each cycle against a timeline model built from accept cycles.
module tb_regalu_sequencer;

    localparam int P_RDY = 41, P_RW = 21, P_RR = 20, P_F = 19, P_WB = 18, P_ILL = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic [31:0] instr = 32'd0;

    logic        rdy1, rw1, rr1, f1, wb1, busy1, ill1;
    logic [4:0]  a1, b1, w1;
    logic [3:0]  op1;
    logic [15:0] ret1;
    logic        rdy3, rw3, rr3, f3, wb3, busy3, ill3;
    logic [4:0]  a3, b3, w3;
    logic [3:0]  op3;
    logic [15:0] ret3;
    logic [41:0] obs [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int          t_acc   [2];
    bit          infl    [2];
    logic [4:0]  m_a     [2];
    logic [4:0]  m_b     [2];
    logic [4:0]  m_w     [2];
    logic [3:0]  m_op    [2];
    int          ill_cyc [2];
    logic [15:0] m_ret   [2];

    always #5 clk = ~clk;

    regalu_sequencer #(.PHASE_LEN(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .instr_ready(rdy1),
        .R_Addr_A(a1), .R_Addr_B(b1), .W_Addr(w1), .ALU_OP(op1), .Reg_Write(rw1),
        .clk_RR(rr1), .clk_F(f1), .clk_WB(wb1), .busy(busy1), .illegal(ill1), .retired_cnt(ret1)
    );

    regalu_sequencer #(.PHASE_LEN(3), .CNT_W(16)) dut3 (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .instr_ready(rdy3),
        .R_Addr_A(a3), .R_Addr_B(b3), .W_Addr(w3), .ALU_OP(op3), .Reg_Write(rw3),
        .clk_RR(rr3), .clk_F(f3), .clk_WB(wb3), .busy(busy3), .illegal(ill3), .retired_cnt(ret3)
    );

    assign obs[0] = {rdy1, a1, b1, w1, op1, rw1, rr1, f1, wb1, busy1, ill1, ret1};
    assign obs[1] = {rdy3, a3, b3, w3, op3, rw3, rr3, f3, wb3, busy3, ill3, ret3};

    function automatic int plen(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic bit m_legal(input logic [31:0] i);
        logic [6:0] opc;
        logic [6:0] f7;
        logic [2:0] fn3;
        opc = i[6:0];
        f7  = i[31:25];
        fn3 = i[14:12];
        return (opc == 7'h33) && ((f7 == 7'h00) || (f7 == 7'h20 && (fn3 == 3'd0 || fn3 == 3'd5)));
    endfunction

    // An instruction accepted at the end of cycle T occupies cycles T+1 .. T+3N.
    function automatic bit m_active(input int d, input int c);
        return infl[d] && (c - t_acc[d]) >= 1 && (c - t_acc[d]) <= 3 * plen(d);
    endfunction

    function automatic logic [41:0] exp_vec(input int d);
        int n, off;
        bit act, rr, f, wb, rw;
        n   = plen(d);
        off = cyc - t_acc[d];
        act = m_active(d, cyc);
        rr  = act && off <= n;
        f   = act && off > n && off <= 2 * n;
        wb  = act && off > 2 * n;
        rw  = wb && (m_w[d] != 5'd0);
        return {!act, m_a[d], m_b[d], m_w[d], m_op[d], rw, rr, f, wb, act,
                (ill_cyc[d] == cyc - 1), m_ret[d]};
    endfunction

    function automatic logic [31:0] legal_instr();
        logic [2:0] fn3;
        logic [6:0] f7;
        logic [4:0] rs1, rs2, rd;
        fn3 = 3'($urandom_range(0, 7));
        rs1 = 5'($urandom);
        rs2 = 5'($urandom);
        rd  = 5'($urandom);
        f7  = ((fn3 == 3'd0 || fn3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        return {f7, rs2, rs1, fn3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int k;
        w = $urandom;
        k = $urandom_range(0, 9);
        if (k < 6) begin
            w = legal_instr();
        end else if (k == 6) begin
            w[6:0] = 7'h13;
        end else if (k == 7) begin
            w = legal_instr();
            w[31:25] = 7'h20;
            w[14:12] = 3'd2;
        end else if (k == 8) begin
            w = legal_instr();
            w[31:25] = 7'h01;
        end
        return w;
    endfunction

    // Advance one clock: model consumes the inputs present at the edge, then settle to the falling edge.
    task automatic step();
        int c;
        @(posedge clk);
        c = cyc;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                infl[d] = 1'b0;
                m_a[d] = 5'd0; m_b[d] = 5'd0; m_w[d] = 5'd0; m_op[d] = 4'd0;
                m_ret[d] = 16'd0;
                ill_cyc[d] = -10;
            end else begin
                if (m_active(d, c) && (c - t_acc[d]) == 3 * plen(d)) m_ret[d] = m_ret[d] + 16'd1;
                if (!m_active(d, c) && instr_valid) begin
                    if (m_legal(instr)) begin
                        infl[d]  = 1'b1;
                        t_acc[d] = c;
                        m_a[d]   = instr[19:15];
                        m_b[d]   = instr[24:20];
                        m_w[d]   = instr[11:7];
                        m_op[d]  = {instr[30], instr[14:12]};
                    end else begin
                        ill_cyc[d] = c;
                    end
                end
            end
        end
        cyc = cyc + 1;
        @(negedge clk);
    endtask

    task automatic drain();
        instr_valid = 1'b0;
        while (m_active(0, cyc) || m_active(1, cyc)) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        total++;
        if (obs[0] !== {1'b1, 41'd0}) begin
            bad++;
            $display("FAIL reset_values got=%h want=%h", obs[0], {1'b1, 41'd0});
        end
        for (int d = 0; d < 2; d++) begin
            total++;
            if (obs[d] !== exp_vec(d)) begin
                bad++;
                $display("FAIL reset_vec n=%0d cyc=%0d got=%h want=%h", plen(d), cyc, obs[d], exp_vec(d));
            end
        end
    endtask

    task automatic test_add();
        logic [2:0] want_st;
        instr = 32'h002081B3;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            want_st = (k <= 3) ? (3'b100 >> (k - 1)) : 3'b000;
            total++;
            if ({rr1, f1, wb1, rw1, rdy1} !== {want_st, (k == 3), (k == 4)}) begin
                bad++;
                $display("FAIL add_phase k=%0d got=%b want=%b", k, {rr1, f1, wb1, rw1, rdy1},
                         {want_st, (k == 3), (k == 4)});
            end
            for (int d = 0; d < 2; d++) begin
                total++;
                if (obs[d] !== exp_vec(d)) begin
                    bad++;
                    $display("FAIL add_vec n=%0d cyc=%0d got=%h want=%h", plen(d), cyc, obs[d], exp_vec(d));
                end
            end
            if (k < 4) step();
        end
        total++;
        if ({a1, b1, w1, op1, ret1} !== {5'd1, 5'd2, 5'd3, 4'd0, 16'd1}) begin
            bad++;
            $display("FAIL add_fields got=%h want=%h", {a1, b1, w1, op1, ret1}, {5'd1, 5'd2, 5'd3, 4'd0, 16'd1});
        end
        drain();
    endtask

    task automatic test_sub();
        int rw_cnt = 0;
        instr = 32'h407302B3;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        instr = 32'hFFFFFFFF;
        for (int k = 1; k <= 10; k++) begin
            if (rw1) rw_cnt++;
            if (k == 3) begin
                total++;
                if ({a1, b1, w1, op1, wb1, rw1} !== {5'd6, 5'd7, 5'd5, 4'b1000, 1'b1, 1'b1}) begin
                    bad++;
                    $display("FAIL sub_wb got=%h want=%h", {a1, b1, w1, op1, wb1, rw1},
                             {5'd6, 5'd7, 5'd5, 4'b1000, 1'b1, 1'b1});
                end
            end
            for (int d = 0; d < 2; d++) begin
                total++;
                if (obs[d] !== exp_vec(d)) begin
                    bad++;
                    $display("FAIL sub_vec n=%0d cyc=%0d got=%h want=%h", plen(d), cyc, obs[d], exp_vec(d));
                end
            end
            step();
        end
        total++;
        if (rw_cnt != 1 || ret1 !== 16'd2) begin
            bad++;
            $display("FAIL sub_rw_count got=%0d/%0d want=1/2", rw_cnt, ret1);
        end
        drain();
    endtask

    task automatic test_x0();
        int st_cnt = 0;
        int rw_cnt = 0;
        instr = 32'h00208033;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            st_cnt += int'(rr1) + int'(f1) + int'(wb1);
            rw_cnt += int'(rw1) + int'(rw3);
            for (int d = 0; d < 2; d++) begin
                total++;
                if (obs[d] !== exp_vec(d)) begin
                    bad++;
                    $display("FAIL x0_vec n=%0d cyc=%0d got=%h want=%h", plen(d), cyc, obs[d], exp_vec(d));
                end
            end
            step();
        end
        total++;
        if (st_cnt != 3 || rw_cnt != 0 || ret1 !== 16'd3) begin
            bad++;
            $display("FAIL x0_write got=%0d/%0d/%0d want=3/0/3", st_cnt, rw_cnt, ret1);
        end
        drain();
    endtask

    task automatic test_illegal();
        instr = 32'h00108093;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        total++;
        if ({ill1, rdy1, rr1, f1, wb1, rw1, a1, b1, w1, op1, ret1} !==
            {1'b1, 1'b1, 4'b0000, 5'd1, 5'd2, 5'd0, 4'd0, 16'd3}) begin
            bad++;
            $display("FAIL illegal_pulse got=%h want=%h", {ill1, rdy1, rr1, f1, wb1, rw1, a1, b1, w1, op1, ret1},
                     {1'b1, 1'b1, 4'b0000, 5'd1, 5'd2, 5'd0, 4'd0, 16'd3});
        end
        for (int k = 0; k < 3; k++) begin
            for (int d = 0; d < 2; d++) begin
                total++;
                if (obs[d] !== exp_vec(d)) begin
                    bad++;
                    $display("FAIL illegal_vec n=%0d cyc=%0d got=%h want=%h", plen(d), cyc, obs[d], exp_vec(d));
                end
            end
            step();
        end
        total++;
        if (ill1 !== 1'b0 || ret1 !== 16'd3) begin
            bad++;
            $display("FAIL illegal_after got=%b/%0d want=0/3", ill1, ret1);
        end
    endtask

    task automatic test_back_to_back();
        int  run  [2] = '{0, 0};
        int  rise [2] = '{-1, -1};
        bit  prev [2] = '{1'b0, 1'b0};
        bit  rr;
        instr_valid = 1'b1;
        for (int k = 0; k < 45; k++) begin
            instr = legal_instr();
            step();
            for (int d = 0; d < 2; d++) begin
                total++;
                if (obs[d] !== exp_vec(d)) begin
                    bad++;
                    $display("FAIL b2b_vec n=%0d cyc=%0d got=%h want=%h", plen(d), cyc, obs[d], exp_vec(d));
                end
                rr = obs[d][P_RR];
                if (rr) run[d]++;
                if (rr && !prev[d]) begin
                    if (rise[d] >= 0) begin
                        total++;
                        if (cyc - rise[d] != 3 * plen(d) + 1) begin
                            bad++;
                            $display("FAIL b2b_spacing n=%0d got=%0d want=%0d", plen(d), cyc - rise[d], 3 * plen(d) + 1);
                        end
                    end
                    rise[d] = cyc;
                end
                if (!rr && prev[d]) begin
                    total++;
                    if (run[d] != plen(d)) begin
                        bad++;
                        $display("FAIL b2b_rr_len n=%0d got=%0d want=%0d", plen(d), run[d], plen(d));
                    end
                    run[d] = 0;
                end
                prev[d] = rr;
            end
        end
        drain();
    endtask

    task automatic test_rst_ex();
        instr = 32'h002081B3;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        step();
        total++;
        if (f1 !== 1'b1) begin
            bad++;
            $display("FAIL rst_ex_in_ex got=%b want=1", f1);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if (obs[0] !== {1'b1, 41'd0}) begin
            bad++;
            $display("FAIL rst_ex_values got=%h want=%h", obs[0], {1'b1, 41'd0});
        end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (wb1 !== 1'b0 || rw1 !== 1'b0 || wb3 !== 1'b0 || rw3 !== 1'b0) begin
                bad++;
                $display("FAIL rst_ex_no_wb k=%0d got=%b want=0000", k, {wb1, rw1, wb3, rw3});
            end
            for (int d = 0; d < 2; d++) begin
                total++;
                if (obs[d] !== exp_vec(d)) begin
                    bad++;
                    $display("FAIL rst_ex_vec n=%0d cyc=%0d got=%h want=%h", plen(d), cyc, obs[d], exp_vec(d));
                end
            end
            step();
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            rst = ($urandom_range(0, 99) == 0);
            instr_valid = ($urandom_range(0, 2) != 0);
            instr = rand_instr();
            step();
            for (int d = 0; d < 2; d++) begin
                total++;
                if (obs[d] !== exp_vec(d)) begin
                    bad++;
                    $display("FAIL random_vec n=%0d cyc=%0d got=%h want=%h", plen(d), cyc, obs[d], exp_vec(d));
                end
            end
        end
        rst = 1'b0;
        drain();
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            t_acc[d] = 0;
            infl[d] = 1'b0;
            ill_cyc[d] = -10;
        end
        @(negedge clk);
        test_reset();
        test_add();
        test_sub();
        test_x0();
        test_illegal();
        test_back_to_back();
        test_rst_ex();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/regalu_sequencer.md
Name: regalu_sequencer

Overview:
- Drives the register-array/ALU datapath (`R_Addr_A`, `R_Addr_B`, `W_Addr`, `ALU_OP`, `Reg_Write`, `clk_RR`, `clk_F`, `clk_WB`) from a stream of RV32I R-type instructions.
- Decodes each accepted instruction into addresses and ALU opcode, then sequences the three datapath phases: register read, ALU/flag latch, write-back.
- Sits between the instruction source (ROM stepper or switch input) and the register/ALU top, replacing manual phase stimulus.

Parameters:
- `PHASE_LEN`, default 1: clock cycles each phase strobe stays high (1..15).
- `CNT_W`, default 16: width of the retired-instruction counter.

Ports:
- `clk` in 1: single system clock, all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `instr_valid` in 1: instruction word present.
- `instr` in 32: RV32I instruction word.
- `instr_ready` out 1: sequencer can accept an instruction.
- `R_Addr_A` out 5: rs1 = `instr[19:15]`.
- `R_Addr_B` out 5: rs2 = `instr[24:20]`.
- `W_Addr` out 5: rd = `instr[11:7]`.
- `ALU_OP` out 4: `{instr[30], instr[14:12]}`.
- `Reg_Write` out 1: register write enable.
- `clk_RR` out 1: register-read phase strobe.
- `clk_F` out 1: ALU result/flag latch phase strobe.
- `clk_WB` out 1: write-back phase strobe.
- `busy` out 1: a sequence is in progress.
- `illegal` out 1: one-cycle pulse when a rejected instruction is consumed.
- `retired_cnt` out `CNT_W`: count of completed write-back phases.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: state IDLE; `instr_ready`=1; all addresses, `ALU_OP`, `Reg_Write`, strobes, `busy`, `illegal` = 0; `retired_cnt`=0.
- FSM states: IDLE, RR, EX, WB. A phase counter counts 0..`PHASE_LEN`-1 within each of RR, EX and WB.
- IDLE:
  - `instr_ready`=1, `busy`=0.
  - Handshake occurs when `instr_valid` and `instr_ready` are both 1 at an edge (cycle T). The instruction is latched at that edge.
- Legality check, all conditions required:
  - opcode `instr[6:0]` = 0110011.
  - funct7 is 0000000 or 0100000.
  - funct7 = 0100000 only with funct3 = 000 or 101.
- Legal instruction:
  - Addresses and `ALU_OP` update at the T edge and are held stable until the next accepted legal instruction.
  - Next state is RR.
- Illegal instruction:
  - `illegal`=1 for exactly cycle T+1.
  - Stays in IDLE; addresses, `ALU_OP` and strobes are unchanged; counter is unchanged.
- Phase timing with `PHASE_LEN`=1 (the handshake cycle T is the last IDLE cycle):
  - Cycle T+1: RR, `clk_RR`=1.
  - Cycle T+2: EX, `clk_F`=1.
  - Cycle T+3: WB, `clk_WB`=1, `Reg_Write`=(rd≠0).
  - Cycle T+4: IDLE.
- General `PHASE_LEN`=N: each phase lasts N cycles with its strobe high throughout.
- Throughput and `busy`:
  - Next accept is possible at the T+3N+1 edge, giving throughput of one instruction per 3N+1 cycles.
  - `busy`=1 and `instr_ready`=0 in RR/EX/WB.
- Strobes are mutually exclusive, registered and glitch-free. At most one of `clk_RR`, `clk_F`, `clk_WB` is high in any cycle.
- `Reg_Write` is high only within WB, and only when rd≠0. Writes to x0 are suppressed, but the WB strobe is still issued and the instruction still counts.
- `retired_cnt` increments by 1 on the final WB cycle edge and wraps modulo 2^`CNT_W`.
- `instr_valid` during busy is ignored; the source must hold it. `instr` changes during busy do not affect the latched fields.
- `rst` asserted in any state:
  - Next edge forces the reset values; the in-flight instruction is discarded.
  - No `Reg_Write` is issued after the reset edge.
  - `rst` has priority over a simultaneous handshake.

Test Plan:
- Reset then `instr`=0x002081B3 (add x3,x1,x2), `PHASE_LEN`=1 -> A=1, B=2, W=3, `ALU_OP`=0000. Strobes `clk_RR`/`clk_F`/`clk_WB` at T+1/T+2/T+3. `Reg_Write`=1 at T+3 only. `retired_cnt`=1. `instr_ready`=1 at T+4.
- `instr`=0x407302B3 (sub x5,x6,x7) -> A=6, B=7, W=5, `ALU_OP`=1000. `Reg_Write` high one cycle in WB.
- `instr`=0x00208033 (add x0,x1,x2) -> all three strobes occur, `Reg_Write` stays 0, `retired_cnt` increments.
- `instr`=0x00108093 (addi) -> `illegal`=1 for one cycle. No strobes, outputs unchanged, `retired_cnt` unchanged, `instr_ready` stays 1.
- `PHASE_LEN`=3, back-to-back valid legal instructions -> each strobe high 3 cycles, accepts spaced 10 cycles, `instr_valid` ignored while `busy`=1.
- `rst` pulsed during EX -> next cycle all outputs at reset values, no WB or `Reg_Write` for that instruction, `retired_cnt`=0.
